// File: rtl/demux_seq_pkg.sv
// Shared definitions for the 1-to-8 demux frame sequencer and its bench:
// channel geometry, FSM states and the demux select encoding.
package demux_seq_pkg;

  localparam int N_CH = 8;
  localparam int CH_W = 3;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_e;

  // The demux treats sel[0] as its MSB, so the channel index is bit-reversed.
  function automatic logic [CH_W-1:0] ch_to_sel(input logic [CH_W-1:0] ch);
    return {ch[0], ch[1], ch[2]};
  endfunction

endpackage

// File: rtl/demux_frame_sequencer.sv
// Serialises one 8-bit frame per handshake onto the demux D/sel/EN inputs.
// Build option DEMUX_SEQ_MSB_FIRST_EN delivers channels 7..0 instead of 0..7.
module demux_frame_sequencer
  import demux_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_CH-1:0] in_data,
  input  logic            hold,
  output logic            D,
  output logic [CH_W-1:0] sel,
  output logic            EN,
  output logic            busy,
  output logic            done
);

`ifdef DEMUX_SEQ_MSB_FIRST_EN
  localparam logic [CH_W-1:0] CH_FIRST = CH_W'(N_CH - 1);
  localparam logic [CH_W-1:0] CH_LAST  = '0;
`else
  localparam logic [CH_W-1:0] CH_FIRST = '0;
  localparam logic [CH_W-1:0] CH_LAST  = CH_W'(N_CH - 1);
`endif

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [N_CH-1:0]   frm_q, frm_d;
  logic              d_q, d_d;
  logic [CH_W-1:0]   sel_q, sel_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CH_W-1:0]   ch_nxt;
  logic              last_free;
  logic              accept;

`ifdef DEMUX_SEQ_MSB_FIRST_EN
  assign ch_nxt = ch_q - CH_W'(1);
`else
  assign ch_nxt = ch_q + CH_W'(1);
`endif

  // ch_q is the channel currently on the outputs; a frame ends when the last
  // channel is showing and no stall is requested, which is also the only
  // point in SHIFT where the next frame may be taken.
  assign last_free = (state_q == ST_SHIFT) && (ch_q == CH_LAST) && !hold;
  assign in_ready  = (state_q == ST_IDLE) || last_free;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    frm_d   = frm_q;
    d_d     = 1'b0;
    sel_d   = sel_q;
    en_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        sel_d  = '0;
        busy_d = 1'b0;
        if (accept) begin
          state_d = ST_SHIFT;
          ch_d    = CH_FIRST;
          frm_d   = in_data;
          d_d     = in_data[CH_FIRST];
          sel_d   = ch_to_sel(CH_FIRST);
          en_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end

      ST_SHIFT: begin
        busy_d = 1'b1;
        if (hold) begin
          sel_d = sel_q;
        end else if (ch_q == CH_LAST) begin
          if (accept) begin
            ch_d  = CH_FIRST;
            frm_d = in_data;
            d_d   = in_data[CH_FIRST];
            sel_d = ch_to_sel(CH_FIRST);
            en_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
            ch_d    = '0;
            sel_d   = '0;
            busy_d  = 1'b0;
          end
        end else begin
          ch_d   = ch_nxt;
          d_d    = frm_q[ch_nxt];
          sel_d  = ch_to_sel(ch_nxt);
          en_d   = 1'b1;
          done_d = (ch_nxt == CH_LAST);
        end
      end

      default: begin
        state_d = ST_IDLE;
        ch_d    = '0;
        sel_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      frm_q   <= '0;
      d_q     <= 1'b0;
      sel_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      frm_q   <= frm_d;
      d_q     <= d_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign D    = d_q;
  assign sel  = sel_q;
  assign EN   = en_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_demux_frame_sequencer.sv
// Directed bench for demux_frame_sequencer: single frame, back-to-back,
// stall, mid-frame reset and input changes after accept.
module tb_demux_frame_sequencer;
  import demux_seq_pkg::*;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      in_data;
  logic            hold;
  logic            D;
  logic [CH_W-1:0] sel;
  logic            EN;
  logic            busy;
  logic            done;

  int n_tests;
  int n_fail;

  // Demux select code for each channel, written out by hand.
  logic [2:0] sel_tbl [8];

  demux_frame_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .hold     (hold),
    .D        (D),
    .sel      (sel),
    .EN       (EN),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Channel presented on the k-th delivery cycle of a frame.
  function automatic int ch_at(input int k);
`ifdef DEMUX_SEQ_MSB_FIRST_EN
    return 7 - k;
`else
    return k;
`endif
  endfunction

  task automatic expect_out(input string tag, input logic en, input logic d,
                            input logic [2:0] s, input logic bz, input logic dn,
                            input logic rdy);
    #1;
    check_val({tag, ".EN"},    32'(EN),       32'(en));
    check_val({tag, ".D"},     32'(D),        32'(d));
    check_val({tag, ".sel"},   32'(sel),      32'(s));
    check_val({tag, ".busy"},  32'(busy),     32'(bz));
    check_val({tag, ".done"},  32'(done),     32'(dn));
    check_val({tag, ".ready"}, 32'(in_ready), 32'(rdy));
  endtask

  initial begin
    logic [7:0] frame;
    logic [7:0] y_seen;
    int ch;
    int idx;

    n_tests = 0;
    n_fail  = 0;
    sel_tbl[0] = 3'b000; sel_tbl[1] = 3'b100; sel_tbl[2] = 3'b010; sel_tbl[3] = 3'b110;
    sel_tbl[4] = 3'b001; sel_tbl[5] = 3'b101; sel_tbl[6] = 3'b011; sel_tbl[7] = 3'b111;

    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    hold     = 1'b0;
    tick();
    tick();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick();
    expect_out("reset", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    hold  = 1'b1;
    tick();
    expect_out("idle_hold", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    hold = 1'b0;

    // Single frame A5
    frame    = 8'hA5;
    in_valid = 1'b1;
    in_data  = frame;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
    y_seen   = 8'h00;
    for (int k = 0; k < 8; k++) begin
      ch = ch_at(k);
      expect_out($sformatf("a5_%0d", k), 1'b1, frame[ch], sel_tbl[ch], 1'b1,
                 (k == 7), (k == 7));
      idx = int'({sel[0], sel[1], sel[2]});
      if (EN && D) y_seen[idx] = 1'b1;
      tick();
    end
    check_val("a5_y_pulses", 32'(y_seen), 32'h0000_00A5);
    expect_out("a5_end", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);

    // Back-to-back FF then 00
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    for (int k = 0; k < 16; k++) begin
      if (k == 7) in_data = 8'h00;
      if (k == 8) in_valid = 1'b0;
      ch = ch_at(k % 8);
      expect_out($sformatf("b2b_%0d", k), 1'b1, (k < 8), sel_tbl[ch], 1'b1,
                 ((k % 8) == 7), ((k % 8) == 7));
      tick();
    end
    expect_out("b2b_end", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);

    // Stall for three cycles after the 4th bit of 81; valid kept high
    frame    = 8'h81;
    in_valid = 1'b1;
    in_data  = frame;
    tick();
    in_data = 8'h7E;
    for (int c = 0; c < 11; c++) begin
      hold = (c >= 3 && c <= 5);
      if (c == 10) in_valid = 1'b0;
      if (c >= 4 && c <= 6) begin
        expect_out($sformatf("hold_%0d", c), 1'b0, 1'b0, sel_tbl[ch_at(3)], 1'b1,
                   1'b0, 1'b0);
      end else begin
        ch = (c < 4) ? ch_at(c) : ch_at(c - 3);
        expect_out($sformatf("hold_%0d", c), 1'b1, frame[ch], sel_tbl[ch], 1'b1,
                   (c == 10), (c == 10 || c == 3) && !hold);
      end
      tick();
    end
    hold = 1'b0;
    expect_out("hold_end", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);

    // Reset after three bits of FF; valid on the reset edge is ignored
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h01;
      end
      ch = ch_at(k);
      #1;
      check_val($sformatf("rst_pre_%0d.EN", k), 32'(EN), 32'd1);
      check_val($sformatf("rst_pre_%0d.D", k),  32'(D),  32'd1);
      tick();
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    expect_out("rst_mid", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    tick();
    expect_out("rst_after", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    frame    = 8'h01;
    in_valid = 1'b1;
    in_data  = frame;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ch = ch_at(k);
      expect_out($sformatf("f01_%0d", k), 1'b1, frame[ch], sel_tbl[ch], 1'b1,
                 (k == 7), (k == 7));
      tick();
    end
    expect_out("f01_end", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);

    // Input data toggles after accept
    frame    = 8'h3C;
    in_valid = 1'b1;
    in_data  = frame;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_data = (k % 2 == 0) ? 8'hC3 : 8'h5A;
      ch = ch_at(k);
      expect_out($sformatf("tog_%0d", k), 1'b1, frame[ch], sel_tbl[ch], 1'b1,
                 (k == 7), (k == 7));
      tick();
    end
    expect_out("tog_end", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
